// File: rtl/acc_pkg.sv
// Shared types for the accumulator write arbiter.
// NUM_ACC accumulators of DATA_W bits each, addressed by ADDR_W bits.
// acc_wr_t is one pending register-file write. It is used both for the
// per-requester slots and for the registered output stage.
package acc_pkg;
  localparam int NUM_ACC = 8;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 8;

  typedef logic [ADDR_W-1:0] acc_addr_t;
  typedef logic [DATA_W-1:0] acc_data_t;

  typedef struct packed {
    acc_addr_t addr;
    acc_data_t data;
  } acc_wr_t;
endpackage

// File: rtl/acc_write_arbiter_if.sv
// Requester-side bundle of the accumulator write arbiter.
// Ports (per requester i, NUM_REQ lanes):
//   req_valid[i] : requester presents a write
//   req_ready[i] : requester's slot is empty
//   req_reg[i]   : target accumulator
//   req_data[i]  : write data
// Handshake: a write transfers on the rising edge where req_valid[i] and
// req_ready[i] are both 1. Once req_valid[i] is raised, the requester holds
// req_valid[i], req_reg[i] and req_data[i] stable until that edge.
// req_ready[i] never depends on req_valid[i].
interface acc_write_arbiter_if #(
  parameter int NUM_REQ = 3
) ();
  import acc_pkg::*;

  logic      [NUM_REQ-1:0] req_valid;
  logic      [NUM_REQ-1:0] req_ready;
  acc_addr_t [NUM_REQ-1:0] req_reg;
  acc_data_t [NUM_REQ-1:0] req_data;

  modport master (
    output req_valid,
    output req_reg,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_reg,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/acc_rr_arbiter.sv
// Combinational round-robin grant.
// Ports:
//   req   : request vector, one bit per requester
//   ptr   : highest-priority index for this cycle
//   grant : one-hot grant, or all zero when nothing is requested
//   any   : 1 when some request was granted
// The first set request at or after ptr wins, searching upward with wrap.
module acc_rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               any
);
  always_comb begin
    grant = '0;
    any   = 1'b0;
    // k is the distance from the pointer. j selects the lane whose index
    // equals (ptr + k) mod NUM_REQ, so each lane index stays a constant.
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!any && req[j] && (j == ((int'(ptr) + k) % NUM_REQ))) begin
          grant[j] = 1'b1;
          any      = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/acc_write_arbiter.sv
// Shares the single accumulator register-file write port between NUM_REQ
// writers. Each writer has a one-entry slot. One full slot per cycle is
// retired, in round-robin order, into a registered output stage that drives
// the register file.
// Ports:
//   CLK, RESET : clock and asynchronous active-high reset
//   req        : requester bundle (valid/ready/reg/data per requester)
//   isWrite    : registered write enable to the register file
//   writeReg   : registered write address
//   writeData  : registered write data
//   grant_id   : requester whose write is on the port; valid when isWrite=1
//   busy       : busy[r]=1 while any write to accumulator r is pending
module acc_write_arbiter
  import acc_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                 CLK,
  input  logic                 RESET,
  acc_write_arbiter_if.slave   req,
  output logic                 isWrite,
  output acc_addr_t            writeReg,
  output acc_data_t            writeData,
  output logic [1:0]           grant_id,
  output logic [NUM_ACC-1:0]   busy
);
  logic [NUM_REQ-1:0] full_q;
  acc_wr_t            slot_q [NUM_REQ];
  acc_wr_t            out_q;
  logic               is_write_q;
  logic [1:0]         grant_id_q;
  logic [1:0]         ptr_q;

  logic [NUM_REQ-1:0] grant_oh;
  logic               any_grant;
  logic [1:0]         grant_idx;
  acc_wr_t            grant_wr;
  logic [1:0]         ptr_next;

  acc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (full_q),
    .ptr   (ptr_q),
    .grant (grant_oh),
    .any   (any_grant)
  );

  // No bypass: a slot emptied at an edge only reports ready after that edge.
  // While RESET is high the slots are held empty, but nothing may be
  // accepted, so ready is also gated by reset.
  assign req.req_ready = ~full_q & {NUM_REQ{~RESET}};

  // One-hot grant to index, plus the granted slot contents.
  always_comb begin
    grant_idx = 2'd0;
    grant_wr  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        grant_idx = 2'(i);
        grant_wr  = slot_q[i];
      end
    end
  end

  assign ptr_next = (grant_idx == 2'(NUM_REQ - 1)) ? 2'd0 : grant_idx + 2'd1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      full_q     <= '0;
      for (int i = 0; i < NUM_REQ; i++) slot_q[i] <= '0;
      out_q      <= '0;
      is_write_q <= 1'b0;
      grant_id_q <= 2'd0;
      ptr_q      <= 2'd0;
    end else begin
      // Accept and grant never hit the same slot at one edge: accept needs
      // the slot empty, grant needs it full.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (any_grant && grant_oh[i]) begin
          full_q[i] <= 1'b0;
        end else if (req.req_valid[i] && !full_q[i]) begin
          full_q[i] <= 1'b1;
          slot_q[i] <= '{addr: req.req_reg[i], data: req.req_data[i]};
        end
      end
      is_write_q <= any_grant;
      if (any_grant) begin
        out_q      <= grant_wr;
        grant_id_q <= grant_idx;
        ptr_q      <= ptr_next;
      end
    end
  end

  // A write stays busy from slot capture until it leaves the output stage.
  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (full_q[i]) busy[slot_q[i].addr] = 1'b1;
    end
    if (is_write_q) busy[out_q.addr] = 1'b1;
  end

  assign isWrite   = is_write_q;
  assign writeReg  = out_q.addr;
  assign writeData = out_q.data;
  assign grant_id  = grant_id_q;
endmodule

// File: tb/tb_acc_write_arbiter.sv
module tb_acc_write_arbiter;
  import acc_pkg::*;

  localparam int NUM_REQ = 3;

  logic               CLK;
  logic               RESET;
  logic               isWrite;
  acc_addr_t          writeReg;
  acc_data_t          writeData;
  logic [1:0]         grant_id;
  logic [NUM_ACC-1:0] busy;

  acc_write_arbiter_if #(.NUM_REQ(NUM_REQ)) req_if ();

  acc_write_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req       (req_if.slave),
    .isWrite   (isWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Expected entry: {grant_id, addr, data}
  logic [12:0] exp_q[$];
  acc_data_t   acc_mem [NUM_ACC];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle with isWrite high must match the head of exp_q.
  // The bench's register-file model takes the write as it is observed.
  always @(negedge CLK) begin
    if (!RESET && isWrite) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {19'd0, grant_id, writeReg, writeData}, 32'h1fff_ffff);
      end else begin
        chk("write", {19'd0, grant_id, writeReg, writeData}, {19'd0, exp_q.pop_front()});
      end
      acc_mem[writeReg] = writeData;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; presents writes on the lanes in mask for one edge.
  task automatic drive(input logic [2:0] mask, input logic [8:0] regs, input logic [23:0] datas);
    req_if.req_reg   = regs;
    req_if.req_data  = datas;
    req_if.req_valid = mask;
    chk("pre_ready", {29'd0, req_if.req_ready & mask}, {29'd0, mask});
    @(posedge CLK);
    #1;
    req_if.req_valid = '0;
  endtask

  // Bounded wait for the port to drain; ends at posedge+1.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge CLK);
    while ((isWrite || busy != '0 || exp_q.size() != 0) && n < 20) begin
      n++;
      @(negedge CLK);
    end
    chk(name, {31'd0, (n >= 20)}, 32'd0);
    @(posedge CLK);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic       exp_r;
    acc_data_t  bp_data;

    for (int i = 0; i < NUM_ACC; i++) acc_mem[i] = '0;
    RESET = 1'b1;
    req_if.req_valid = '0;
    req_if.req_reg   = '0;
    req_if.req_data  = '0;

    // Reset held for 3 cycles
    repeat (2) @(negedge CLK);
    chk("rst_ready",   {29'd0, req_if.req_ready}, 32'd0);
    chk("rst_iswrite", {31'd0, isWrite}, 32'd0);
    chk("rst_busy",    {24'd0, busy}, 32'd0);
    chk("rst_wreg",    {29'd0, writeReg}, 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("rel_ready", {29'd0, req_if.req_ready}, 32'h7);
    @(posedge CLK);
    #1;

    // Round robin, pointer 0: order 0,1,2 on consecutive cycles
    exp_q.push_back({2'd0, 3'd0, 8'h10});
    exp_q.push_back({2'd1, 3'd1, 8'h11});
    exp_q.push_back({2'd2, 3'd2, 8'h12});
    drive(3'b111, {3'd2, 3'd1, 3'd0}, {8'h12, 8'h11, 8'h10});
    @(posedge CLK);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("rr0_back2back", {31'd0, isWrite}, 32'd1);
      @(posedge CLK);
    end
    #1;
    wait_idle("rr0_drain");

    // Single write: requester 1, reg 5 = A7 (pointer moves to 2)
    exp_q.push_back({2'd1, 3'd5, 8'hA7});
    drive(3'b010, {3'd0, 3'd5, 3'd0}, {8'h00, 8'hA7, 8'h00});
    @(negedge CLK);
    chk("single_busy_e0", {24'd0, busy}, 32'h20);
    @(posedge CLK);
    @(negedge CLK);
    chk("single_busy_e1", {24'd0, busy}, 32'h20);
    @(posedge CLK);
    @(negedge CLK);
    chk("single_busy_e2", {24'd0, busy}, 32'h0);
    chk("single_acc5",    {24'd0, acc_mem[5]}, 32'hA7);
    chk("single_ready",   {29'd0, req_if.req_ready}, 32'h7);
    @(posedge CLK);
    #1;

    // Round robin, pointer 2: order 2,0,1
    exp_q.push_back({2'd2, 3'd2, 8'h22});
    exp_q.push_back({2'd0, 3'd0, 8'h20});
    exp_q.push_back({2'd1, 3'd1, 8'h21});
    drive(3'b111, {3'd2, 3'd1, 3'd0}, {8'h22, 8'h21, 8'h20});
    wait_idle("rr2_drain");

    // Requester 2 alone to reg 6 (pointer returns to 0)
    exp_q.push_back({2'd2, 3'd6, 8'h5A});
    drive(3'b100, {3'd6, 3'd0, 3'd0}, {8'h5A, 8'h00, 8'h00});
    wait_idle("reg6_drain");
    chk("acc6", {24'd0, acc_mem[6]}, 32'h5A);

    // Same-address collision: reg 3 = 11 (req0) then 22 (req2)
    exp_q.push_back({2'd0, 3'd3, 8'd11});
    exp_q.push_back({2'd2, 3'd3, 8'd22});
    drive(3'b101, {3'd3, 3'd0, 3'd3}, {8'd22, 8'd0, 8'd11});
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("coll_busy3", {24'd0, busy}, 32'h08);
      @(posedge CLK);
    end
    @(negedge CLK);
    chk("coll_busy_clear", {24'd0, busy}, 32'h0);
    chk("coll_acc3", {24'd0, acc_mem[3]}, 32'd22);
    @(posedge CLK);
    #1;

    // Back-pressure: requester 0 holds valid, reg 7, incrementing data
    bp_data = 8'h30;
    exp_r   = 1'b1;
    req_if.req_reg[0]  = 3'd7;
    req_if.req_data[0] = bp_data;
    req_if.req_valid   = 3'b001;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge CLK);
      chk("bp_ready", {31'd0, req_if.req_ready[0]}, {31'd0, exp_r});
      chk("bp_iswrite", {31'd0, isWrite}, {31'd0, (cyc >= 2 && (cyc % 2) == 0)});
      if (exp_r) exp_q.push_back({2'd0, 3'd7, bp_data});
      @(posedge CLK);
      #1;
      if (exp_r) begin
        bp_data = bp_data + 8'd1;
        req_if.req_data[0] = bp_data;
      end
      exp_r = !exp_r;
    end
    req_if.req_valid = '0;
    wait_idle("bp_drain");
    chk("bp_acc7", {24'd0, acc_mem[7]}, 32'h35);

    // Reset mid-operation (pointer is 1: requester 1 goes first)
    exp_q.push_back({2'd1, 3'd4, 8'hC4});
    drive(3'b111, {3'd7, 3'd4, 3'd1}, {8'hC7, 8'hC4, 8'hC1});
    @(negedge CLK);
    chk("mid_busy_full", {24'd0, busy}, 32'h92);
    @(posedge CLK);
    @(negedge CLK);
    chk("mid_iswrite", {31'd0, isWrite}, 32'd1);
    #1;
    RESET = 1'b1;
    #1;
    chk("mid_rst_iswrite", {31'd0, isWrite}, 32'd0);
    chk("mid_rst_busy",    {24'd0, busy}, 32'h0);
    chk("mid_rst_ready",   {29'd0, req_if.req_ready}, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      chk("post_rst_quiet", {31'd0, isWrite}, 32'd0);
    end
    chk("post_rst_ready", {29'd0, req_if.req_ready}, 32'h7);
    chk("post_rst_busy",  {24'd0, busy}, 32'h0);
    chk("post_rst_q",     exp_q.size(), 32'd0);
    chk("post_rst_acc1",  {24'd0, acc_mem[1]}, 32'h21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
